cp0_except_ctrl: RTL and testbench

//  Consumes the prioritised exception_type code and commits it in the CP0 register file.

---
 rtl/cp0_except_ctrl.sv | 152 +++++++++++++++
 tb/tb_cp0_except_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_except_ctrl.sv
// CP0 exception commit: EPC/Cause/Status/BadVAddr update, pipeline flush and redirect,
// Count/Compare timer and hardware/timer interrupt merge into Cause.IP.
module cp0_except_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] RESET_STAT = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] exception_type,
  input  logic [31:0] exc_pc,
  input  logic        in_delay_slot,
  input  logic [31:0] bad_addr,
  input  logic [5:0]  ext_int,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [4:0]  raddr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [31:0] CODE_ERET    = 32'h0000_000E;

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exc;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        count_phase;

  logic        exc_take;
  logic [4:0]  exc_code;
  logic        eret;
  logic        mtc0;
  logic        wr_compare;

  always_comb begin
    // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
    exc_take = 1'b1;
    exc_code = 5'd0;
    case (exception_type)
      32'h1:   exc_code = 5'd0;
      32'h4:   exc_code = 5'd4;
      32'h5:   exc_code = 5'd5;
      32'h8:   exc_code = 5'd8;
      32'h9:   exc_code = 5'd9;
      32'hA:   exc_code = 5'd10;
      32'hC:   exc_code = 5'd12;
      32'hD:   exc_code = 5'd13;
      default: exc_take = 1'b0;
    endcase
  end

  assign eret       = (exception_type == CODE_ERET);
  // A faulting or flushed instruction must never commit its MTC0.
  assign mtc0       = we && (exception_type == 32'd0);
  assign wr_compare = mtc0 && (waddr == REG_COMPARE);

  assign flush    = |exception_type;
  assign new_pc   = eret ? epc : EXC_VECTOR;
  assign status_o = {9'd0, RESET_STAT[22], 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_o  = {cause_bd, timer_int, 14'd0, cause_ip_hw, cause_ip_sw, 1'b0, cause_exc, 2'd0};
  assign epc_o    = epc;

  always_comb begin
    rdata = 32'd0;
    case (raddr)
      REG_BADVADDR: rdata = badvaddr;
      REG_COUNT:    rdata = count;
      REG_COMPARE:  rdata = compare;
      REG_STATUS:   rdata = status_o;
      REG_CAUSE:    rdata = cause_o;
      REG_EPC:      rdata = epc;
      default:      rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_im   <= RESET_STAT[15:8];
      status_exl  <= RESET_STAT[1];
      status_ie   <= RESET_STAT[0];
      cause_bd    <= 1'b0;
      cause_ip_hw <= 6'd0;
      cause_ip_sw <= 2'd0;
      cause_exc   <= 5'd0;
      epc         <= 32'd0;
      badvaddr    <= 32'd0;
      count       <= 32'd0;
      compare     <= 32'd0;
      count_phase <= 1'b0;
      timer_int   <= 1'b0;
    end else begin
      cause_ip_hw <= {ext_int[5] | timer_int, ext_int[4:0]};
      count_phase <= ~count_phase;
      if (count_phase) count <= count + 32'd1;

      if (wr_compare)              timer_int <= 1'b0;
      else if (count == compare)   timer_int <= 1'b1;

      if (exc_take) begin
        // A nested exception keeps the EPC/BD of the outer one.
        if (!status_exl) begin
          epc      <= in_delay_slot ? exc_pc - 32'd4 : exc_pc;
          cause_bd <= in_delay_slot;
        end
        status_exl <= 1'b1;
        cause_exc  <= exc_code;
        if (exc_code == 5'd4 || exc_code == 5'd5) badvaddr <= bad_addr;
      end else if (eret) begin
        status_exl <= 1'b0;
      end

      // The Count load is placed after the increment so the write takes priority.
      if (mtc0) begin
        case (waddr)
          REG_COUNT: begin
            count       <= wdata;
            count_phase <= 1'b0;
          end
          REG_COMPARE: compare <= wdata;
          REG_STATUS: begin
            status_im  <= wdata[15:8];
            status_exl <= wdata[1];
            status_ie  <= wdata[0];
          end
          REG_CAUSE: cause_ip_sw <= wdata[9:8];
          REG_EPC:   epc         <= wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Self-checking bench for cp0_except_ctrl: directed scenarios plus a randomized run
// checked against a register-level behavioural model.
module tb_cp0_except_ctrl;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
  localparam logic [31:0] RESET_STAT = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] exception_type;
  logic [31:0] exc_pc;
  logic        in_delay_slot;
  logic [31:0] bad_addr;
  logic [5:0]  ext_int;
  logic        we;
  logic [4:0]  waddr;
  logic [4:0]  raddr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cp0_except_ctrl #(.EXC_VECTOR(EXC_VECTOR), .RESET_STAT(RESET_STAT)) dut (
    .clk(clk), .resetn(resetn), .exception_type(exception_type), .exc_pc(exc_pc),
    .in_delay_slot(in_delay_slot), .bad_addr(bad_addr), .ext_int(ext_int), .we(we),
    .waddr(waddr), .raddr(raddr), .wdata(wdata), .rdata(rdata), .flush(flush),
    .new_pc(new_pc), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .timer_int(timer_int)
  );

  // Behavioural model: architectural register words; Count is a loaded base plus
  // elapsed cycles halved.
  logic [31:0] m_status, m_cause, m_epc, m_bad, m_cmp, m_count_base;
  int unsigned m_ticks;
  logic        m_timer;

  function automatic logic [31:0] m_count();
    return m_count_base + (m_ticks >> 1);
  endfunction

  function automatic logic [31:0] m_cause_word();
    return {m_cause[31], m_timer, m_cause[29:0]};
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count();
      5'd11:   return m_cmp;
      5'd12:   return m_status;
      5'd13:   return m_cause_word();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exc_code_of(input logic [31:0] t);
    case (t)
      32'h1:   return 0;
      32'h4:   return 4;
      32'h5:   return 5;
      32'h8:   return 8;
      32'h9:   return 9;
      32'hA:   return 10;
      32'hC:   return 12;
      32'hD:   return 13;
      default: return -1;
    endcase
  endfunction

  always @(posedge clk) begin : model_edge
    int   code;
    logic wr;
    logic match;
    logic old_timer;
    if (!resetn) begin
      m_status     = RESET_STAT;
      m_cause      = 32'd0;
      m_epc        = 32'd0;
      m_bad        = 32'd0;
      m_cmp        = 32'd0;
      m_count_base = 32'd0;
      m_ticks      = 0;
      m_timer      = 1'b0;
    end else begin
      code      = exc_code_of(exception_type);
      wr        = we && (exception_type == 32'd0);
      match     = (m_count() == m_cmp);
      old_timer = m_timer;
      if (wr && waddr == 5'd11) m_timer = 1'b0;
      else if (match)           m_timer = 1'b1;
      m_cause[15:10] = {ext_int[5] | old_timer, ext_int[4:0]};
      m_ticks = m_ticks + 1;
      if (code >= 0) begin
        if (!m_status[1]) begin
          m_epc      = in_delay_slot ? exc_pc - 32'd4 : exc_pc;
          m_cause[31] = in_delay_slot;
        end
        m_status[1]  = 1'b1;
        m_cause[6:2] = code[4:0];
        if (code == 4 || code == 5) m_bad = bad_addr;
      end else if (exception_type == 32'hE) begin
        m_status[1] = 1'b0;
      end
      if (wr) begin
        case (waddr)
          5'd9: begin
            m_count_base = wdata;
            m_ticks      = 0;
          end
          5'd11: m_cmp = wdata;
          5'd12: m_status = (m_status & ~32'h0000_FF03) | (wdata & 32'h0000_FF03);
          5'd13: m_cause[9:8] = wdata[9:8];
          5'd14: m_epc = wdata;
          default: ;
        endcase
      end
    end
  end

  task automatic idle();
    exception_type = 32'd0;
    exc_pc         = 32'd0;
    in_delay_slot  = 1'b0;
    bad_addr       = 32'd0;
    ext_int        = 6'd0;
    we             = 1'b0;
    waddr          = 5'd0;
    raddr          = 5'd0;
    wdata          = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    repeat (2) tick();
    n_checks++; if (status_o !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_status: got %h expected %h", status_o, 32'h0040_0000); end
    n_checks++; if (cause_o !== 32'd0) begin n_fail++; $display("FAIL reset_cause: got %h expected 0", cause_o); end
    n_checks++; if (epc_o !== 32'd0) begin n_fail++; $display("FAIL reset_epc: got %h expected 0", epc_o); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b expected 0", flush); end
    n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL reset_timer: got %b expected 0", timer_int); end
    resetn = 1'b1;
  endtask

  task automatic test_syscall();
    exception_type = 32'h8; exc_pc = 32'hBFC0_0100; in_delay_slot = 1'b0;
    #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL syscall_flush: got %b expected 1", flush); end
    n_checks++; if (new_pc !== 32'hBFC0_0380) begin n_fail++; $display("FAIL syscall_new_pc: got %h expected bfc00380", new_pc); end
    tick();
    idle();
    n_checks++; if (epc_o !== 32'hBFC0_0100) begin n_fail++; $display("FAIL syscall_epc: got %h expected bfc00100", epc_o); end
    n_checks++; if (cause_o[6:2] !== 5'd8) begin n_fail++; $display("FAIL syscall_exccode: got %0d expected 8", cause_o[6:2]); end
    n_checks++; if (status_o[1] !== 1'b1) begin n_fail++; $display("FAIL syscall_exl: got %b expected 1", status_o[1]); end
  endtask

  task automatic test_mtc0_masks();
    mtc0(5'd12, 32'hFFFF_FFFF);
    n_checks++; if (status_o !== 32'h0040_FF03) begin n_fail++; $display("FAIL status_mask: got %h expected 0040ff03", status_o); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    n_checks++; if (cause_o[9:8] !== 2'b11 || cause_o[29:16] !== 14'd0 || cause_o[6:2] !== 5'd8)
      begin n_fail++; $display("FAIL cause_mask: got %h expected sw=11 hi=0 exc=8", cause_o); end
    mtc0(5'd12, 32'd0);
    n_checks++; if (status_o !== 32'h0040_0000) begin n_fail++; $display("FAIL status_clear: got %h expected 00400000", status_o); end
  endtask

  task automatic test_delay_slot_adel();
    exception_type = 32'h4; exc_pc = 32'h8000_0010; in_delay_slot = 1'b1; bad_addr = 32'h3;
    tick();
    idle();
    raddr = 5'd8;
    #1;
    n_checks++; if (epc_o !== 32'h8000_000C) begin n_fail++; $display("FAIL adel_epc: got %h expected 8000000c", epc_o); end
    n_checks++; if (cause_o[31] !== 1'b1) begin n_fail++; $display("FAIL adel_bd: got %b expected 1", cause_o[31]); end
    n_checks++; if (rdata !== 32'h3) begin n_fail++; $display("FAIL adel_badvaddr: got %h expected 3", rdata); end
    exception_type = 32'hE;
    #1;
    n_checks++; if (new_pc !== 32'h8000_000C) begin n_fail++; $display("FAIL eret_new_pc: got %h expected 8000000c", new_pc); end
    tick();
    idle();
    n_checks++; if (status_o[1] !== 1'b0) begin n_fail++; $display("FAIL eret_exl: got %b expected 0", status_o[1]); end
    n_checks++; if (cause_o[6:2] !== 5'd4) begin n_fail++; $display("FAIL eret_exccode: got %0d expected 4", cause_o[6:2]); end
  endtask

  task automatic test_nested();
    exception_type = 32'h9; exc_pc = 32'h0000_0100;
    tick();
    exception_type = 32'hC; exc_pc = 32'h0000_1234; in_delay_slot = 1'b1;
    #1;
    n_checks++; if (new_pc !== 32'hBFC0_0380) begin n_fail++; $display("FAIL nested_new_pc: got %h expected bfc00380", new_pc); end
    tick();
    idle();
    n_checks++; if (epc_o !== 32'h0000_0100) begin n_fail++; $display("FAIL nested_epc: got %h expected 00000100", epc_o); end
    n_checks++; if (cause_o[6:2] !== 5'd12) begin n_fail++; $display("FAIL nested_exccode: got %0d expected 12", cause_o[6:2]); end
    n_checks++; if (cause_o[31] !== 1'b0) begin n_fail++; $display("FAIL nested_bd: got %b expected 0", cause_o[31]); end
    mtc0(5'd12, 32'd0);
  endtask

  task automatic test_write_suppress();
    exception_type = 32'h9; exc_pc = 32'h0000_2000;
    we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
    tick();
    idle();
    n_checks++; if (epc_o !== 32'h0000_2000) begin n_fail++; $display("FAIL suppress_epc: got %h expected 00002000", epc_o); end
    mtc0(5'd12, 32'd0);
  endtask

  task automatic test_timer();
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd5);
    n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL timer_cleared: got %b expected 0", timer_int); end
    for (int i = 0; i < 40 && timer_int !== 1'b1; i++) tick();
    n_checks++; if (timer_int !== 1'b1) begin n_fail++; $display("FAIL timer_set: got %b expected 1 within 40 cycles", timer_int); end
    n_checks++; if (cause_o[30] !== 1'b1) begin n_fail++; $display("FAIL timer_ti: got %b expected 1", cause_o[30]); end
    tick();
    n_checks++; if (cause_o[15] !== 1'b1) begin n_fail++; $display("FAIL timer_ip7: got %b expected 1", cause_o[15]); end
    mtc0(5'd11, 32'd100);
    n_checks++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL timer_rewrite: got %b expected 0", timer_int); end
  endtask

  task automatic test_count_wrap();
    mtc0(5'd9, 32'hFFFF_FFFF);
    raddr = 5'd9;
    #1;
    n_checks++; if (rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_load: got %h expected ffffffff", rdata); end
    tick();
    n_checks++; if (rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_phase: got %h expected ffffffff", rdata); end
    tick();
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0", rdata); end
    raddr = 5'd10;
    #1;
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL unimpl_read: got %h expected 0", rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    for (int cyc = 0; cyc < 400; cyc++) begin
      resetn = ($urandom_range(0, 59) != 0);
      case ($urandom_range(0, 14))
        0, 1, 2, 3: exception_type = 32'h0;
        4:  exception_type = 32'h1;
        5:  exception_type = 32'h4;
        6:  exception_type = 32'h5;
        7:  exception_type = 32'h8;
        8:  exception_type = 32'h9;
        9:  exception_type = 32'hA;
        10: exception_type = 32'hC;
        11: exception_type = 32'hD;
        12: exception_type = 32'hE;
        13: exception_type = 32'h3;
        default: exception_type = $urandom;
      endcase
      exc_pc        = $urandom;
      in_delay_slot = 1'($urandom_range(0, 1));
      bad_addr      = $urandom;
      ext_int       = 6'($urandom);
      we            = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 6))
        0: waddr = 5'd9;
        1: waddr = 5'd11;
        2: waddr = 5'd12;
        3: waddr = 5'd13;
        4: waddr = 5'd14;
        5: waddr = 5'd8;
        default: waddr = 5'($urandom);
      endcase
      wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      raddr = 5'($urandom_range(0, 15));
      #1;
      exp_pc = (exception_type == 32'hE) ? m_epc : EXC_VECTOR;
      n_checks++; if (flush !== (exception_type != 32'd0)) begin n_fail++; $display("FAIL rnd_flush cyc %0d: got %b expected %b", cyc, flush, exception_type != 32'd0); end
      if (exception_type != 32'd0) begin
        n_checks++; if (new_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_new_pc cyc %0d: got %h expected %h", cyc, new_pc, exp_pc); end
      end
      n_checks++; if (rdata !== m_rdata(raddr)) begin n_fail++; $display("FAIL rnd_rdata cyc %0d reg %0d: got %h expected %h", cyc, raddr, rdata, m_rdata(raddr)); end
      tick();
      n_checks++; if (status_o !== m_status) begin n_fail++; $display("FAIL rnd_status cyc %0d: got %h expected %h", cyc, status_o, m_status); end
      n_checks++; if (cause_o !== m_cause_word()) begin n_fail++; $display("FAIL rnd_cause cyc %0d: got %h expected %h", cyc, cause_o, m_cause_word()); end
      n_checks++; if (epc_o !== m_epc) begin n_fail++; $display("FAIL rnd_epc cyc %0d: got %h expected %h", cyc, epc_o, m_epc); end
      n_checks++; if (timer_int !== m_timer) begin n_fail++; $display("FAIL rnd_timer cyc %0d: got %b expected %b", cyc, timer_int, m_timer); end
    end
    resetn = 1'b1;
    idle();
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_mtc0_masks();
    test_delay_slot_adel();
    test_nested();
    test_write_suppress();
    test_timer();
    test_count_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
